// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the MULTU/DIVU sequencer.
package muldiv_pkg;
    localparam int          WIDTH    = 32;
    localparam int          CNT_W    = 5;
    localparam logic [3:0]  ALU_ADD  = 4'b0010;
    localparam logic [3:0]  ALU_SUB  = 4'b0110;
    localparam logic        OP_MULTU = 1'b0;
    localparam logic        OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage issue, shared-ALU and HI/LO result bundle of the multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             rd_req;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sig;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport slave (
        input  start, op, src_a, src_b, rd_req, alu_result, alu_cout,
        output alu_a, alu_b, alu_sig, busy, done, stall, hi, lo
    );

    modport master (
        output start, op, src_a, src_b, rd_req, alu_result, alu_cout,
        input  alu_a, alu_b, alu_sig, busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide around the shared ALU.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  state_t           i_state,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_operand,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_cout,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [3:0]       o_alu_sig,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt
);
    logic [WIDTH-1:0] w_sh;
    logic             w_ok;

    // The bit shifted out of hi is the 33rd remainder bit; if set, the subtract always fits.
    assign w_sh = {i_hi[WIDTH-2:0], i_lo[WIDTH-1]};
    assign w_ok = i_hi[WIDTH-1] | i_alu_cout;

    always_comb begin
        o_alu_a   = '0;
        o_alu_b   = '0;
        o_alu_sig = ALU_ADD;
        o_hi_nxt  = i_hi;
        o_lo_nxt  = i_lo;
        case (i_state)
            S_MUL: begin
                o_alu_a  = i_hi;
                o_alu_b  = i_lo[0] ? i_operand : '0;
                o_hi_nxt = {i_alu_cout, i_alu_result[WIDTH-1:1]};
                o_lo_nxt = {i_alu_result[0], i_lo[WIDTH-1:1]};
            end
            S_DIV: begin
                o_alu_a   = w_sh;
                o_alu_b   = i_operand;
                o_alu_sig = ALU_SUB;
                o_hi_nxt  = w_ok ? i_alu_result : w_sh;
                o_lo_nxt  = {i_lo[WIDTH-2:0], w_ok};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller time-sharing the EX-stage ALU; owns FSM, counter and HI/LO.
//  state  | meaning
//  IDLE   | waiting for start; HI/LO hold the last result
//  MUL    | one shift-add multiply step per cycle
//  DIV    | one restoring divide step per cycle
//  DONE   | HI/LO final, done pulses for this cycle
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_nxt = (bus.op == OP_DIVU) ? S_DIV : S_MUL;
            end
            S_MUL, S_DIV: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_operand <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= (bus.op == OP_DIVU) ? bus.src_a : bus.src_b;
            r_operand <= (bus.op == OP_DIVU) ? bus.src_b : bus.src_a;
        end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_state      (r_state),
        .i_hi         (r_hi),
        .i_lo         (r_lo),
        .i_operand    (r_operand),
        .i_alu_result (bus.alu_result),
        .i_alu_cout   (bus.alu_cout),
        .o_alu_a      (bus.alu_a),
        .o_alu_b      (bus.alu_b),
        .o_alu_sig    (bus.alu_sig),
        .o_hi_nxt     (w_hi_nxt),
        .o_lo_nxt     (w_lo_nxt)
    );

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.stall = bus.rd_req & (w_busy | w_accept);
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: table vectors, mid-op restart/reset sequences and random ops vs. an arithmetic model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add, or subtract as a + ~b + 1 so carry-out means "no borrow".
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        if (bus.alu_sig == ALU_SUB) alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
    end
    assign bus.alu_result = alu_sum[31:0];
    assign bus.alu_cout   = alu_sum[32];

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rdq;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [63:0] ref_model(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_MULTU) return {32'h0, a} * {32'h0, b};
        if (b == 32'h0)     return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input logic rdq,
                          input int restart_at, input logic [63:0] exp, input string name);
        bit          seen = 1'b0;
        int          lat = 0;
        int          busy_n = 0;
        int          stall_err = 0;
        logic [63:0] res = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.rd_req = rdq;
        #1;
        if (bus.stall !== rdq) stall_err++;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (restart_at > 0 && i == restart_at) begin
                bus.start = 1'b1; bus.op = ~op; bus.src_a = ~a; bus.src_b = b + 32'd3;
            end else if (restart_at > 0 && i == restart_at + 1) begin
                bus.start = 1'b0;
            end
            #1;
            if (bus.busy) busy_n++;
            if (bus.stall !== (rdq & bus.busy)) stall_err++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = i;
                res  = {bus.hi, bus.lo};
            end
        end
        check({name, "/latency"}, 64'(lat), 64'd33);
        check({name, "/busy_cycles"}, 64'(busy_n), 64'd33);
        check({name, "/stall"}, 64'(stall_err), 64'd0);
        check({name, "/hilo"}, res, exp);
        @(negedge clk);
        bus.rd_req = 1'b0;
        #1;
        check({name, "/after_done"}, {62'h0, bus.busy, bus.done}, 64'h0);
        check({name, "/hilo_hold"}, {bus.hi, bus.lo}, exp);
        check({name, "/idle_alu"}, {bus.alu_a, bus.alu_b[27:0], bus.alu_sig}, {60'h0, ALU_ADD});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic        r_rdq;
        int          done_seen;

        vecs[0] = '{OP_MULTU, 32'd7,         32'd6,         1'b1, 32'h0,         32'd42,        "mul_7x6"};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "mul_max"};
        vecs[2] = '{OP_MULTU, 32'h1234_5678, 32'h10,        1'b1, 32'h1,         32'h2345_6780, "mul_carry"};
        vecs[3] = '{OP_MULTU, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'h0,         32'h0,         "mul_zero"};
        vecs[4] = '{OP_DIVU,  32'd100,       32'd7,         1'b1, 32'd2,         32'd14,        "div_100_7"};
        vecs[5] = '{OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h0,         "div_msb"};
        vecs[6] = '{OP_DIVU,  32'd5,         32'd0,         1'b1, 32'd5,         32'hFFFF_FFFF, "div_by_zero"};
        vecs[7] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0,         32'hFFFF_FFFF, "div_by_one"};
        vecs[8] = '{OP_DIVU,  32'd1000000,   32'd1000,      1'b0, 32'h0,         32'd1000,      "div_exact"};

        bus.start = 1'b0; bus.op = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.rd_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("reset/status", {61'h0, bus.busy, bus.done, bus.stall}, 64'h0);
        check("reset/hilo", {bus.hi, bus.lo}, 64'h0);
        check("reset/alu", {bus.alu_a, bus.alu_b[27:0], bus.alu_sig}, {60'h0, ALU_ADD});

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rdq, 0, {vecs[i].hi, vecs[i].lo}, vecs[i].name);

        // A second start while a multiply is running must be ignored.
        run_op(OP_MULTU, 32'd7, 32'd6, 1'b1, 10, {32'h0, 32'd42}, "restart_ignored");

        // Asynchronous reset in the middle of a divide aborts it without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("abort/busy_before", {63'h0, bus.busy}, 64'h1);
        rst_n = 1'b0; bus.rd_req = 1'b1;
        #1;
        check("abort/status", {61'h0, bus.busy, bus.done, bus.stall}, 64'h0);
        check("abort/hilo", {bus.hi, bus.lo}, 64'h0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst_n = 1'b1; bus.rd_req = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort/no_done", 64'(done_seen), 64'd0);
        run_op(OP_MULTU, 32'd123, 32'd456, 1'b0, 0, {32'h0, 32'd56088}, "after_abort");

        for (int n = 0; n < 30; n++) begin
            r_op  = 1'($urandom_range(0, 1));
            r_a   = $urandom;
            r_b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            r_rdq = 1'($urandom_range(0, 1));
            run_op(r_op, r_a, r_b, r_rdq, 0, ref_model(r_op, r_a, r_b), $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
